fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC and drives instruction memory, then loads the IF/ID pipeline register.
- Consumes the output of the 32-bit PC-select MUX as next_pc.
- Produces pc_plus4, which feeds that MUX's non-branch input; the MUX's other input is the branch target.
- Handles hazard-unit stalls, branch redirects/flushes and a variable-latency memory handshake.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 50 +++++
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end: datapath width, reset
// PC, the NOP encoding used to clear instruction registers and the fetch
// controller state encoding.
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // IDLE : no request (one cycle after reset release)
  // REQ  : request outstanding at pc
  // DROP : redirect arrived mid-request; finish the old request and discard it
  // HOLD : a fetched instruction is parked in the skid buffer during a stall
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Instruction / pc+4 / valid register with load, hold and flush controls.
// Used both as the IF/ID pipeline register and as the fetch skid buffer.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (clears all fields)
//   load           capture load_instr / load_pc_plus4 / load_valid
//   flush          clear valid only, other fields held (ignored when load=1)
//   load_instr     instruction to capture
//   load_pc_plus4  pc+4 of that instruction
//   load_valid     valid bit to capture
//   instr          registered instruction
//   pc_plus4       registered pc+4
//   valid          registered valid bit (0 = bubble / empty)
// With neither load nor flush asserted the register holds.
// ---------------------------------------------------------------------------
module if_id_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_pc_plus4,
  input  logic              load_valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc_plus4,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= DATA_W'(INSTR_NOP);
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
      valid    <= load_valid;
    end else if (flush) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives
// instruction memory through a req/ready handshake and loads IF/ID. Handles
// hazard-unit stalls (with a one-entry skid buffer so an instruction that
// arrives during a stall is not lost) and branch redirects (flushing IF/ID
// and discarding any in-flight response).
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   next_pc         PC-select MUX output, sampled only when the PC updates
//   redirect        taken branch/jump this cycle; flushes fetch
//   stall           hazard unit hold of IF/ID and PC
//   pc_plus4        combinational pc + 4 (to the MUX non-branch input)
//   imem_req        fetch request
//   imem_addr       fetch address (always equals pc)
//   imem_rdata      instruction from memory, valid with imem_ready
//   imem_ready      memory completes the request this cycle
//   if_id_instr     IF/ID instruction
//   if_id_pc_plus4  IF/ID pc+4 of that instruction
//   if_id_valid     IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                DATA_W   = mips_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] next_pc,
  input  logic              redirect,
  input  logic              stall,
  output logic [DATA_W-1:0] pc_plus4,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc_plus4,
  output logic              if_id_valid
);

  fetch_state_t      state, state_n;
  logic [DATA_W-1:0] pc, pc_n, pend_pc;
  logic              pc_load, pend_load;

  logic              ifid_load, ifid_flush, ifid_from_skid;
  logic [DATA_W-1:0] ifid_d_instr, ifid_d_pc_plus4;
  logic              ifid_d_valid;

  logic              skid_load, skid_flush;
  logic [DATA_W-1:0] skid_instr, skid_pc_plus4;
  logic              skid_valid;

  assign pc_plus4  = pc + DATA_W'(4);
  assign imem_addr = pc;

  // IF/ID is filled either straight from memory or from the skid buffer
  // when a stall that caught a fetched instruction is released.
  assign ifid_d_instr    = ifid_from_skid ? skid_instr    : imem_rdata;
  assign ifid_d_pc_plus4 = ifid_from_skid ? skid_pc_plus4 : pc_plus4;
  assign ifid_d_valid    = ifid_from_skid ? skid_valid    : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state <= state_n;
      if (pc_load)   pc      <= pc_n;
      if (pend_load) pend_pc <= next_pc;
    end
  end

  always_comb begin
    state_n        = state;
    imem_req       = 1'b0;
    pc_load        = 1'b0;
    pc_n           = next_pc;
    pend_load      = 1'b0;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_flush     = 1'b0;

    unique case (state)
      IDLE: begin
        state_n = REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            pc_load = 1'b1;
          end else begin
            // Address must stay stable until the memory answers, so the
            // new target waits in pend_pc.
            pend_load = 1'b1;
            state_n   = DROP;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            ifid_load = 1'b1;
            pc_load   = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_n   = HOLD;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          pend_load  = 1'b1;
          ifid_flush = 1'b1;
        end
        if (imem_ready) begin
          pc_load = 1'b1;
          pc_n    = redirect ? next_pc : pend_pc;
          state_n = REQ;
        end
      end

      HOLD: begin
        if (redirect) begin
          skid_flush = 1'b1;
          ifid_flush = 1'b1;
          pc_load    = 1'b1;
          state_n    = REQ;
        end else if (!stall) begin
          ifid_load      = 1'b1;
          ifid_from_skid = 1'b1;
          pc_load        = 1'b1;
          state_n        = REQ;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  if_id_reg #(.DATA_W(DATA_W)) u_if_id (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (ifid_load),
    .flush         (ifid_flush),
    .load_instr    (ifid_d_instr),
    .load_pc_plus4 (ifid_d_pc_plus4),
    .load_valid    (ifid_d_valid),
    .instr         (if_id_instr),
    .pc_plus4      (if_id_pc_plus4),
    .valid         (if_id_valid)
  );

  if_id_reg #(.DATA_W(DATA_W)) u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (skid_load),
    .flush         (skid_flush),
    .load_instr    (imem_rdata),
    .load_pc_plus4 (pc_plus4),
    .load_valid    (1'b1),
    .instr         (skid_instr),
    .pc_plus4      (skid_pc_plus4),
    .valid         (skid_valid)
  );

endmodule
